// File: rtl/count_chk_pkg.sv
// Shared types and constants for the count checker: FSM state encoding,
// default geometry and the width of the violation counter.
package count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int DEF_WIDTH    = 3;
  localparam int DEF_LOCK_LEN = 4;
  localparam int ERR_CNT_W    = 8;

endpackage

// File: rtl/count_checker_if.sv
// Sample/status bundle between a count source (master) and the checker (slave).
interface count_checker_if #(
  parameter int WIDTH = count_chk_pkg::DEF_WIDTH
);
  import count_chk_pkg::*;

  logic [WIDTH-1:0]     count_in;
  logic                 count_valid;
  logic                 clr_err;
  logic                 locked;
  logic                 error;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic [1:0]           state;

  modport master (
    output count_in, count_valid, clr_err,
    input  locked, error, err_cnt, state
  );

  modport slave (
    input  count_in, count_valid, clr_err,
    output locked, error, err_cnt, state
  );

endinterface

// File: rtl/count_chk_sat_ctr.sv
// Saturating violation counter; a clear in the same cycle as an increment
// leaves the counter at 1.
module count_chk_sat_ctr
  import count_chk_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [ERR_CNT_W-1:0] cnt
);

  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets a default before any branch so this block never infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) cnt_d = '0;
    if (inc && (cnt_d != '1)) cnt_d = cnt_d + ERR_CNT_W'(1);
  end

  // NOTE: registers are updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_checker.sv
// Sequence checker for a free-running wrap-around counter: locks after LOCK_LEN
// consecutive correct samples and flags breaks once locked.
// Define COUNT_CHK_RESTART_TOL_EN to accept a jump to 0 while locked as a restart.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_LEN = DEF_LOCK_LEN
) (
  input  logic            clk,
  input  logic            rst,
  count_checker_if.slave  bus
);

  localparam int RUN_W = $clog2(LOCK_LEN + 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               locked_q, locked_d;
  logic               error_q, error_d;
  logic               err_inc;
  logic               err_clr;
  logic               match;
  logic               restart;
  logic [WIDTH-1:0]   next_exp;

  assign match    = (bus.count_in == exp_q);
  assign next_exp = bus.count_in + WIDTH'(1);

`ifdef COUNT_CHK_RESTART_TOL_EN
  assign restart = (bus.count_in == '0);
`else
  assign restart = 1'b0;
`endif

  // err_cnt only moves on sampled cycles, including its clear.
  assign err_clr = bus.count_valid & bus.clr_err;

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    error_d = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.count_valid) begin
          exp_d   = next_exp;
          run_d   = RUN_W'(1);
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (bus.count_valid) begin
          exp_d = next_exp;
          if (match) begin
            run_d = run_q + RUN_W'(1);
            if (run_d == RUN_W'(LOCK_LEN)) state_d = LOCKED;
          end else begin
            run_d = RUN_W'(1);
          end
        end
      end
      LOCKED: begin
        if (bus.count_valid) begin
          exp_d = next_exp;
          if (!match) begin
            run_d   = RUN_W'(1);
            state_d = SYNC;
            if (!restart) begin
              error_d = 1'b1;
              err_inc = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  count_chk_sat_ctr u_err_ctr (
    .clk (clk),
    .rst (rst),
    .clr (err_clr),
    .inc (err_inc),
    .cnt (bus.err_cnt)
  );

  assign bus.locked = locked_q;
  assign bus.error  = error_q;
  assign bus.state  = state_q;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker (WIDTH=3, LOCK_LEN=4): the driver queues
// the hand-derived outputs expected after each edge, the monitor compares them.
module tb_count_checker;

  typedef struct packed {
    logic [1:0] st;
    logic       lk;
    logic       er;
    logic [7:0] ec;
  } exp_t;

  localparam int S_IDLE = 0;
  localparam int S_SYNC = 1;
  localparam int S_LOCK = 2;

  logic clk;
  logic rst;

  count_checker_if #(.WIDTH(3)) bus ();

  count_checker #(.WIDTH(3), .LOCK_LEN(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   step_no   = 0;

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Monitor: outputs settle one cycle after the edge that sampled the vector.
  exp_t mon_e;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        step_no++;
        check($sformatf("step%0d state", step_no),   int'(bus.state),   int'(mon_e.st));
        check($sformatf("step%0d locked", step_no),  int'(bus.locked),  int'(mon_e.lk));
        check($sformatf("step%0d error", step_no),   int'(bus.error),   int'(mon_e.er));
        check($sformatf("step%0d err_cnt", step_no), int'(bus.err_cnt), int'(mon_e.ec));
      end
    end
  end

  task automatic step(input bit r, input bit v, input int c, input bit clr,
                      input int es, input int el, input int ee, input int ec);
    exp_t e;
    @(negedge clk);
    rst             = r;
    bus.count_valid = v;
    bus.count_in    = 3'(c % 8);
    bus.clr_err     = clr;
    e.st = 2'(es);
    e.lk = 1'(el);
    e.er = 1'(ee);
    e.ec = 8'(ec);
    exp_q.push_back(e);
  endtask

  // Ordinary sampled value, no clear, no reset.
  task automatic smp(input int c, input int es, input int el, input int ee, input int ec);
    step(1'b1, 1'b1, c, 1'b0, es, el, ee, ec);
  endtask

  int e_v;
  int m;
  int cnt;
  int restart_ec;

  initial begin
    rst             = 1'b0;
    bus.count_valid = 1'b0;
    bus.count_in    = '0;
    bus.clr_err     = 1'b0;

    // Reset, including valid/clr activity that must be ignored.
    step(1'b0, 1'b0, 0, 1'b0, S_IDLE, 0, 0, 0);
    step(1'b0, 1'b1, 5, 1'b1, S_IDLE, 0, 0, 0);

    // Acquire lock on 0,1,2,3.
    smp(0, S_SYNC, 0, 0, 0);
    smp(1, S_SYNC, 0, 0, 0);
    smp(2, S_SYNC, 0, 0, 0);
    smp(3, S_LOCK, 1, 0, 0);

    // Stay locked through the 7 -> 0 wrap.
    smp(4, S_LOCK, 1, 0, 0);
    smp(5, S_LOCK, 1, 0, 0);
    smp(6, S_LOCK, 1, 0, 0);
    smp(7, S_LOCK, 1, 0, 0);
    smp(0, S_LOCK, 1, 0, 0);
    smp(1, S_LOCK, 1, 0, 0);

    // Valid low with a wrong value: everything holds.
    step(1'b1, 1'b0, 6, 1'b0, S_LOCK, 1, 0, 0);
    smp(2, S_LOCK, 1, 0, 0);

    // Break at 3 -> 5, single error pulse, relock on 6,7,0.
    smp(3, S_LOCK, 1, 0, 0);
    smp(5, S_SYNC, 0, 1, 1);
    smp(6, S_SYNC, 0, 0, 1);
    smp(7, S_SYNC, 0, 0, 1);
    smp(0, S_LOCK, 1, 0, 1);

    // Stuck counter, then valid-low hold in SYNC, then a silent SYNC mismatch.
    smp(1, S_LOCK, 1, 0, 1);
    smp(1, S_SYNC, 0, 1, 2);
    step(1'b1, 1'b0, 2, 1'b0, S_SYNC, 0, 0, 2);
    smp(2, S_SYNC, 0, 0, 2);
    smp(5, S_SYNC, 0, 0, 2);
    smp(6, S_SYNC, 0, 0, 2);
    smp(7, S_SYNC, 0, 0, 2);
    smp(0, S_LOCK, 1, 0, 2);

    // Third error, relock at 7 with err_cnt=3.
    smp(1, S_LOCK, 1, 0, 2);
    smp(4, S_SYNC, 0, 1, 3);
    smp(5, S_SYNC, 0, 0, 3);
    smp(6, S_SYNC, 0, 0, 3);
    smp(7, S_LOCK, 1, 0, 3);

    // Reset while locked with valid and clr asserted.
    step(1'b0, 1'b1, 0, 1'b1, S_IDLE, 0, 0, 0);

    // Relock, then jump 4 -> 0.
    smp(0, S_SYNC, 0, 0, 0);
    smp(1, S_SYNC, 0, 0, 0);
    smp(2, S_SYNC, 0, 0, 0);
    smp(3, S_LOCK, 1, 0, 0);
    smp(4, S_LOCK, 1, 0, 0);
`ifdef COUNT_CHK_RESTART_TOL_EN
    restart_ec = 0;
    smp(0, S_SYNC, 0, 0, 0);
`else
    restart_ec = 1;
    smp(0, S_SYNC, 0, 1, 1);
`endif
    smp(1, S_SYNC, 0, 0, restart_ec);
    smp(2, S_SYNC, 0, 0, restart_ec);
    smp(3, S_LOCK, 1, 0, restart_ec);

    // Clear alone on a matching sample.
    step(1'b1, 1'b1, 4, 1'b1, S_LOCK, 1, 0, 0);

    // 256 break/relock rounds drive err_cnt into saturation.
    e_v = 5;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      m = (e_v + 2) % 8;
      if (m == 0) m = (e_v + 3) % 8;
      cnt = (cnt < 255) ? cnt + 1 : 255;
      smp(m,     S_SYNC, 0, 1, cnt);
      smp(m + 1, S_SYNC, 0, 0, cnt);
      smp(m + 2, S_SYNC, 0, 0, cnt);
      smp(m + 3, S_LOCK, 1, 0, cnt);
      e_v = (m + 4) % 8;
    end

    // Clear together with a locked mismatch leaves exactly one error counted.
    m = (e_v + 2) % 8;
    if (m == 0) m = (e_v + 3) % 8;
    step(1'b1, 1'b1, m, 1'b1, S_SYNC, 0, 1, 1);
    smp(m + 1, S_SYNC, 0, 0, 1);
    smp(m + 2, S_SYNC, 0, 0, 1);
    smp(m + 3, S_LOCK, 1, 0, 1);
    step(1'b1, 1'b0, 0, 1'b0, S_LOCK, 1, 0, 1);

    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    #2;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/count_checker.md
COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The module SHALL be clocked by a single clock and reset by a synchronous, active-low reset.
REQ-002 Parameter WIDTH, default 3, SHALL set the width of the observed count.
REQ-003 Parameter LOCK_LEN, default 4, SHALL set the number of consecutive correct samples needed to reach lock.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst  input  1  synchronous reset, active low (0 = reset).
REQ-006 Port count_in  input  WIDTH  count value from the counter under observation.
REQ-007 Port count_valid  input  1  count_in is sampled this cycle.
REQ-008 Port clr_err  input  1  clears err_cnt.
REQ-009 Port locked  output  1  checker is in LOCKED.
REQ-010 Port error  output  1  one-cycle pulse for each detected sequence violation.
REQ-011 Port err_cnt  output  8  saturating violation count.
REQ-012 Port state  output  2  current state encoding.

Function
REQ-013 States SHALL be IDLE=0, SYNC=1 and LOCKED=2; encoding 3 SHALL be unreachable and SHALL recover to IDLE.
REQ-014 Internal registers SHALL be exp (WIDTH bits, the expected next value) and run (the current run length).
REQ-015 The module SHALL act only on cycles where count_valid=1; with count_valid=0, state, exp, run and err_cnt SHALL hold, and error SHALL be 0.
REQ-016 IDLE, valid sample: the module SHALL set exp to count_in+1 mod 2^WIDTH, set run to 1, and go to SYNC.
REQ-017 SYNC, match (count_in==exp): the module SHALL increment run and set exp to count_in+1; when the new run equals LOCK_LEN it SHALL go to LOCKED.
REQ-018 SYNC, mismatch: the module SHALL set run to 1 and exp to count_in+1, stay in SYNC, and raise no error.
REQ-019 LOCKED, match: the module SHALL set exp to count_in+1 and stay in LOCKED.
REQ-020 LOCKED, mismatch: the module SHALL pulse error in the next cycle, increment err_cnt, set exp to count_in+1 and run to 1, and go to SYNC.
REQ-021 Wrap-around SHALL be a match: 2^WIDTH-1 followed by 0 is a correct sample.
REQ-022 A repeated value, such as a stuck counter, SHALL be a mismatch.
REQ-023 err_cnt SHALL saturate at 255 and SHALL not wrap.
REQ-024 When clr_err and a LOCKED mismatch occur in the same cycle, err_cnt SHALL become 1.
REQ-025 When clr_err occurs alone, err_cnt SHALL become 0.
REQ-026 All outputs SHALL be registered, with 1-cycle latency from the sampling edge.

Reset
REQ-027 When rst=0 at a clock edge, the module SHALL set state=IDLE, exp=0, run=0, locked=0, error=0 and err_cnt=0, whatever operation is in progress.
REQ-028 While rst=0, the module SHALL ignore count_valid and clr_err.

Configuration
REQ-029 Macro COUNT_CHK_RESTART_TOL_EN SHALL control restart tolerance.
- Defined: in LOCKED, a mismatch with count_in==0 SHALL be treated as a legal counter restart: no error pulse, no err_cnt change, exp=1, run=1, go to SYNC.
- Undefined: this case SHALL be an ordinary mismatch as in REQ-020.

Structure
REQ-030 Shared package count_chk_pkg SHALL hold the state typedef (IDLE, SYNC, LOCKED), the default WIDTH and LOCK_LEN constants, and the err_cnt width constant (8).
REQ-031 Sub-module count_chk_sat_ctr SHALL implement the 8-bit saturating counter with clear and increment inputs, with clear applied before increment.

Verification
REQ-032 The bench SHALL cover the following scenarios with WIDTH=3 and LOCK_LEN=4.
- Release rst, then stream 0,1,2,3 with valid=1 -> locked=1 one cycle after the 4th sample; error never asserted.
- Lock, then stream 5,6,7,0,1 -> wrap accepted; locked stays 1; err_cnt=0.
- Lock at 3, then present 5 -> error=1 for exactly one cycle; err_cnt=1; state=SYNC; then 6,7,0 -> locked=1 again.
- Lock at 4, then present 0 -> with macro defined: error=0, err_cnt=0, state=SYNC; without it: error=1, err_cnt=1.
- Force 256 mismatches while cycling lock and break -> err_cnt saturates at 255; clr_err together with a mismatch -> err_cnt=1.
- Drive rst=0 in LOCKED with err_cnt=3, holding valid=1 -> next cycle state=IDLE, err_cnt=0, locked=0; toggle valid low mid-stream -> all registers hold.
